// File: rtl/operand_fetch_pkg.sv
// Shared widths and helpers for the operand-fetch stage and its bypass muxes.
package operand_fetch_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;

   localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

   function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
      return r == ZERO_REG;
   endfunction

endpackage

// File: rtl/operand_bypass.sv
// Merges one register-file read port with the previous cycle's writeback
// and the hardwired zero register.
module operand_bypass
   import operand_fetch_pkg::*;
(
   input  logic              zero_hardwired,
   input  logic [REG_W-1:0]  s1_reg,
   input  logic              lastwr_valid,
   input  logic [REG_W-1:0]  lastwr_reg,
   input  logic [DATA_W-1:0] lastwr_data,
   input  logic [DATA_W-1:0] rf_q,
   output logic [DATA_W-1:0] operand
);

   // The file returns the pre-write value when read and write share an edge,
   // so only the single most recent write needs forwarding.
   always_comb begin
      operand = rf_q;
      if (zero_hardwired && is_zero_reg(s1_reg)) begin
         operand = '0;
      end else if (lastwr_valid && (lastwr_reg == s1_reg)) begin
         operand = lastwr_data;
      end
   end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch: drives register-file read/write ports,
// absorbs the one-cycle read latency and bypasses the last writeback.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int unsigned PAYLOAD_W          = 32,
   parameter bit          ZERO_REG_HARDWIRED = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset,

   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [REG_W-1:0]     in_rs,
   input  logic [REG_W-1:0]     in_rt,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 flush,

   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_a,
   output logic [DATA_W-1:0]    out_b,
   output logic [PAYLOAD_W-1:0] out_payload,

   input  logic                 wb_valid,
   input  logic [REG_W-1:0]     wb_reg,
   input  logic [DATA_W-1:0]    wb_data,

   output logic                 rf_enable,
   output logic [REG_W-1:0]     rf_rdaddress_a,
   output logic [REG_W-1:0]     rf_rdaddress_b,
   output logic                 rf_wren,
   output logic [REG_W-1:0]     rf_wraddress,
   output logic [DATA_W-1:0]    rf_data,
   input  logic [DATA_W-1:0]    rf_qa,
   input  logic [DATA_W-1:0]    rf_qb
);

   localparam logic ZERO_HW = ZERO_REG_HARDWIRED;

   logic                 s1_valid;
   logic [REG_W-1:0]     s1_rs;
   logic [REG_W-1:0]     s1_rt;
   logic [PAYLOAD_W-1:0] s1_payload;

   logic                 lastwr_valid;
   logic [REG_W-1:0]     lastwr_reg;
   logic [DATA_W-1:0]    lastwr_data;

   logic                 accept;
   logic                 wren;

   assign in_ready = !s1_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Held registers are re-read every cycle so a stalled operand tracks
   // writebacks that land while execute is not ready.
   assign rf_rdaddress_a = accept ? in_rs : s1_rs;
   assign rf_rdaddress_b = accept ? in_rt : s1_rt;

   assign wren         = !reset && wb_valid && !(ZERO_HW && is_zero_reg(wb_reg));
   assign rf_enable    = !reset;
   assign rf_wren      = wren;
   assign rf_wraddress = wb_reg;
   assign rf_data      = wb_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid     <= 1'b0;
         s1_rs        <= '0;
         s1_rt        <= '0;
         s1_payload   <= '0;
         lastwr_valid <= 1'b0;
         lastwr_reg   <= '0;
         lastwr_data  <= '0;
      end else begin
         if (accept) begin
            s1_valid   <= 1'b1;
            s1_rs      <= in_rs;
            s1_rt      <= in_rt;
            s1_payload <= in_payload;
         end else if (flush || out_ready) begin
            s1_valid <= 1'b0;
         end
         lastwr_valid <= wren;
         lastwr_reg   <= wb_reg;
         lastwr_data  <= wb_data;
      end
   end

   assign out_valid   = s1_valid;
   assign out_payload = s1_payload;

   operand_bypass u_bypass_a (
      .zero_hardwired (ZERO_HW),
      .s1_reg         (s1_rs),
      .lastwr_valid   (lastwr_valid),
      .lastwr_reg     (lastwr_reg),
      .lastwr_data    (lastwr_data),
      .rf_q           (rf_qa),
      .operand        (out_a)
   );

   operand_bypass u_bypass_b (
      .zero_hardwired (ZERO_HW),
      .s1_reg         (s1_rt),
      .lastwr_valid   (lastwr_valid),
      .lastwr_reg     (lastwr_reg),
      .lastwr_data    (lastwr_data),
      .rf_q           (rf_qb),
      .operand        (out_b)
   );

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: behavioural register file plus an architectural
// shadow and a scoreboard of expected operands.
module tb_operand_fetch;

   localparam int unsigned PW = 32;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_rs;
   logic [4:0]    in_rt;
   logic [PW-1:0] in_payload;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_a;
   logic [31:0]   out_b;
   logic [PW-1:0] out_payload;
   logic          wb_valid;
   logic [4:0]    wb_reg;
   logic [31:0]   wb_data;
   logic          rf_enable;
   logic [4:0]    rf_rdaddress_a;
   logic [4:0]    rf_rdaddress_b;
   logic          rf_wren;
   logic [4:0]    rf_wraddress;
   logic [31:0]   rf_data;
   logic [31:0]   rf_qa;
   logic [31:0]   rf_qb;

   always #5 clock = ~clock;

   operand_fetch #(.PAYLOAD_W(PW), .ZERO_REG_HARDWIRED(1'b1)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_rs(in_rs), .in_rt(in_rt),
      .in_payload(in_payload), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_payload(out_payload),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
      .rf_enable(rf_enable), .rf_rdaddress_a(rf_rdaddress_a), .rf_rdaddress_b(rf_rdaddress_b),
      .rf_wren(rf_wren), .rf_wraddress(rf_wraddress), .rf_data(rf_data),
      .rf_qa(rf_qa), .rf_qb(rf_qb)
   );

   // Register file: registered reads that return the pre-write value.
   logic [31:0] mem [32];
   always @(posedge clock) begin
      if (rf_enable) begin
         rf_qa <= mem[rf_rdaddress_a];
         rf_qb <= mem[rf_rdaddress_b];
         if (rf_wren) mem[rf_wraddress] <= rf_data;
      end
   end

   typedef struct {
      logic [31:0]   a;
      logic [31:0]   b;
      logic [PW-1:0] p;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] shadow [32];
   int          checks   = 0;
   int          failures = 0;

   function automatic logic [31:0] arch(input logic [4:0] r);
      return (r == 5'd0) ? 32'h0 : shadow[r];
   endfunction

   task automatic idle();
      in_valid = 1'b0; in_rs = '0; in_rt = '0; in_payload = '0;
      flush = 1'b0; out_ready = 1'b1;
      wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
   endtask

   task automatic accept_in(input logic [4:0] rs, input logic [4:0] rt, input logic [PW-1:0] p);
      in_valid = 1'b1; in_rs = rs; in_rt = rt; in_payload = p;
   endtask

   task automatic write_wb(input logic [4:0] r, input logic [31:0] d);
      wb_valid = 1'b1; wb_reg = r; wb_data = d;
   endtask

   // Advances one clock edge, keeping the shadow and scoreboard in step.
   task automatic tick();
      logic acc, pop;
      exp_t e;
      acc = in_valid && in_ready;
      pop = out_valid && (out_ready || flush);
      @(posedge clock);
      if (reset) begin
         sb.delete();
      end else begin
         if (pop && sb.size() > 0) void'(sb.pop_front());
         if (wb_valid && wb_reg != 5'd0) shadow[wb_reg] = wb_data;
         if (acc) begin
            e.a = arch(in_rs); e.b = arch(in_rt); e.p = in_payload;
            sb.push_back(e);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      write_wb(5'd9, 32'h999);
      repeat (2) begin
         @(negedge clock);
         checks++; if (rf_enable !== 1'b0) begin failures++; $display("FAIL reset_rf_enable: got %b expected 0", rf_enable); end
         checks++; if (rf_wren !== 1'b0) begin failures++; $display("FAIL reset_rf_wren: got %b expected 0", rf_wren); end
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
         tick();
      end
      reset = 1'b0;
      idle();
      @(negedge clock);
      checks++; if (rf_enable !== 1'b1) begin failures++; $display("FAIL post_reset_rf_enable: got %b expected 1", rf_enable); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
      tick();
   endtask

   task automatic test_basic();
      idle();
      write_wb(5'd5, 32'h1234);
      @(negedge clock);
      checks++; if (rf_wren !== 1'b1) begin failures++; $display("FAIL basic_wren: got %b expected 1", rf_wren); end
      checks++; if (rf_wraddress !== 5'd5) begin failures++; $display("FAIL basic_wraddr: got %0d expected 5", rf_wraddress); end
      checks++; if (rf_data !== 32'h1234) begin failures++; $display("FAIL basic_wrdata: got %h expected 00001234", rf_data); end
      tick();
      idle();
      repeat (2) begin @(negedge clock); tick(); end
      accept_in(5'd5, 5'd0, 32'hA5A5_0001);
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready: got %b expected 1", in_ready); end
      checks++; if (rf_rdaddress_a !== 5'd5) begin failures++; $display("FAIL basic_rdaddr_a: got %0d expected 5", rf_rdaddress_a); end
      checks++; if (rf_rdaddress_b !== 5'd0) begin failures++; $display("FAIL basic_rdaddr_b: got %0d expected 0", rf_rdaddress_b); end
      tick();
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
      checks++; if (out_a !== 32'h1234) begin failures++; $display("FAIL basic_out_a: got %h expected 00001234", out_a); end
      checks++; if (out_b !== 32'h0) begin failures++; $display("FAIL basic_out_b: got %h expected 00000000", out_b); end
      if (sb.size() == 0) begin checks++; failures++; $display("FAIL basic_sb: got empty expected 1 entry"); end
      else begin
         checks++; if (out_payload !== sb[0].p) begin failures++; $display("FAIL basic_payload: got %h expected %h", out_payload, sb[0].p); end
      end
      tick();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
      tick();
   endtask

   task automatic test_bypass();
      idle();
      accept_in(5'd7, 5'd5, 32'hB0B0_0002);
      write_wb(5'd7, 32'hAAAA);
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bypass_in_ready: got %b expected 1", in_ready); end
      tick();
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bypass_out_valid: got %b expected 1", out_valid); end
      checks++; if (out_a !== 32'hAAAA) begin failures++; $display("FAIL bypass_out_a: got %h expected 0000aaaa", out_a); end
      if (sb.size() == 0) begin checks++; failures++; $display("FAIL bypass_sb: got empty expected 1 entry"); end
      else begin
         checks++; if (out_b !== sb[0].b) begin failures++; $display("FAIL bypass_out_b: got %h expected %h", out_b, sb[0].b); end
         checks++; if (out_payload !== sb[0].p) begin failures++; $display("FAIL bypass_payload: got %h expected %h", out_payload, sb[0].p); end
      end
      tick();
   endtask

   task automatic test_stall();
      idle();
      accept_in(5'd3, 5'd4, 32'hC0C0_0003);
      @(negedge clock);
      tick();
      for (int k = 1; k <= 4; k++) begin
         idle();
         out_ready = 1'b0;
         accept_in(5'd6, 5'd7, 32'hC0C0_0004);
         if (k == 2) write_wb(5'd3, 32'h55);
         @(negedge clock);
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid[%0d]: got %b expected 1", k, out_valid); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", k, in_ready); end
         checks++; if (rf_rdaddress_a !== 5'd3) begin failures++; $display("FAIL stall_rdaddr[%0d]: got %0d expected 3", k, rf_rdaddress_a); end
         checks++; if (out_a !== arch(5'd3)) begin failures++; $display("FAIL stall_out_a[%0d]: got %h expected %h", k, out_a, arch(5'd3)); end
         checks++; if (out_b !== arch(5'd4)) begin failures++; $display("FAIL stall_out_b[%0d]: got %h expected %h", k, out_b, arch(5'd4)); end
         if (k >= 3) begin
            checks++; if (out_a !== 32'h55) begin failures++; $display("FAIL stall_tracks_wb[%0d]: got %h expected 00000055", k, out_a); end
         end
         checks++; if (out_payload !== 32'hC0C0_0003) begin failures++; $display("FAIL stall_payload[%0d]: got %h expected c0c00003", k, out_payload); end
         tick();
      end
      idle();
      accept_in(5'd6, 5'd7, 32'hC0C0_0004);
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_in_ready: got %b expected 1", in_ready); end
      tick();
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_next_valid: got %b expected 1", out_valid); end
      if (sb.size() == 0) begin checks++; failures++; $display("FAIL stall_sb: got empty expected 1 entry"); end
      else begin
         checks++; if (out_a !== sb[0].a) begin failures++; $display("FAIL stall_next_a: got %h expected %h", out_a, sb[0].a); end
         checks++; if (out_payload !== sb[0].p) begin failures++; $display("FAIL stall_next_payload: got %h expected %h", out_payload, sb[0].p); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i <= 8; i++) begin
         idle();
         if (i < 8) accept_in(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 32'h5000_0000 + 32'(i));
         if ($urandom_range(0, 1) == 1) write_wb(5'($urandom_range(0, 31)), $urandom);
         @(negedge clock);
         if (i < 8) begin
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
         end
         if (i > 0) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
            if (sb.size() == 0) begin checks++; failures++; $display("FAIL stream_sb[%0d]: got empty expected entry", i); end
            else begin
               checks++; if (out_a !== sb[0].a) begin failures++; $display("FAIL stream_a[%0d]: got %h expected %h", i, out_a, sb[0].a); end
               checks++; if (out_b !== sb[0].b) begin failures++; $display("FAIL stream_b[%0d]: got %h expected %h", i, out_b, sb[0].b); end
               checks++; if (out_payload !== 32'h5000_0000 + 32'(i - 1)) begin failures++; $display("FAIL stream_order[%0d]: got %h expected %h", i, out_payload, 32'h5000_0000 + 32'(i - 1)); end
            end
         end
         tick();
      end
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
      tick();
   endtask

   task automatic test_zero_reg();
      idle();
      write_wb(5'd0, 32'hFFFF);
      @(negedge clock);
      checks++; if (rf_wren !== 1'b0) begin failures++; $display("FAIL zero_wren: got %b expected 0", rf_wren); end
      tick();
      idle();
      accept_in(5'd0, 5'd5, 32'hD0D0_0005);
      @(negedge clock);
      tick();
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL zero_valid: got %b expected 1", out_valid); end
      checks++; if (out_a !== 32'h0) begin failures++; $display("FAIL zero_out_a: got %h expected 00000000", out_a); end
      if (sb.size() == 0) begin checks++; failures++; $display("FAIL zero_sb: got empty expected 1 entry"); end
      else begin
         checks++; if (out_b !== sb[0].b) begin failures++; $display("FAIL zero_out_b: got %h expected %h", out_b, sb[0].b); end
      end
      tick();
   endtask

   task automatic test_flush();
      idle();
      accept_in(5'd5, 5'd6, 32'hF1);
      @(negedge clock);
      tick();
      idle();
      out_ready = 1'b0;
      flush = 1'b1;
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
      tick();
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_kill: got %b expected 0", out_valid); end
      tick();
      idle();
      accept_in(5'd8, 5'd1, 32'hF2);
      @(negedge clock);
      tick();
      idle();
      flush = 1'b1;
      accept_in(5'd9, 5'd2, 32'hF3);
      @(negedge clock);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_acc_in_ready: got %b expected 1", in_ready); end
      tick();
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_acc_valid: got %b expected 1", out_valid); end
      if (sb.size() == 0) begin checks++; failures++; $display("FAIL flush_sb: got empty expected 1 entry"); end
      else begin
         checks++; if (out_payload !== sb[0].p) begin failures++; $display("FAIL flush_acc_payload: got %h expected %h", out_payload, sb[0].p); end
         checks++; if (out_a !== sb[0].a) begin failures++; $display("FAIL flush_acc_a: got %h expected %h", out_a, sb[0].a); end
      end
      tick();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drain: got %b expected 0", out_valid); end
      tick();
   endtask

   task automatic test_reset_stall();
      idle();
      accept_in(5'd5, 5'd6, 32'hE1);
      @(negedge clock);
      tick();
      idle();
      out_ready = 1'b0;
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_stall_valid: got %b expected 1", out_valid); end
      tick();
      idle();
      out_ready = 1'b0;
      reset = 1'b1;
      write_wb(5'd11, 32'h77);
      @(negedge clock);
      checks++; if (rf_enable !== 1'b0) begin failures++; $display("FAIL rst_stall_enable: got %b expected 0", rf_enable); end
      checks++; if (rf_wren !== 1'b0) begin failures++; $display("FAIL rst_stall_wren: got %b expected 0", rf_wren); end
      tick();
      reset = 1'b0;
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_stall_cleared: got %b expected 0", out_valid); end
      checks++; if (rf_enable !== 1'b1) begin failures++; $display("FAIL rst_stall_reenable: got %b expected 1", rf_enable); end
      tick();
      idle();
      accept_in(5'd11, 5'd5, 32'hE2);
      @(negedge clock);
      tick();
      idle();
      @(negedge clock);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_dropped_valid: got %b expected 1", out_valid); end
      if (sb.size() == 0) begin checks++; failures++; $display("FAIL rst_sb: got empty expected 1 entry"); end
      else begin
         checks++; if (out_a !== sb[0].a) begin failures++; $display("FAIL rst_dropped_write: got %h expected %h", out_a, sb[0].a); end
         checks++; if (out_b !== sb[0].b) begin failures++; $display("FAIL rst_out_b: got %h expected %h", out_b, sb[0].b); end
      end
      tick();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]    = 32'hDEAD_0000 | 32'(i);
         shadow[i] = 32'hDEAD_0000 | 32'(i);
      end
      mem[0] = 32'hBAD0_BAD0;
      reset = 1'b1;
      idle();
      test_reset();
      test_basic();
      test_bypass();
      test_stall();
      test_back_to_back();
      test_zero_reg();
      test_flush();
      test_reset_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
